// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes stage: substitutes BYTES_PER_CYCLE bytes of the
// held 128-bit state per cycle through a replicated inverse S-box bank.
module inv_sub_bytes_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state
);

    localparam int unsigned NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 inverse S-box, entry b at bits [8*b +: 8]
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t             fsm;
    logic [CNT_W-1:0] cnt;
    logic [0:127]     data;
    logic [0:127]     sub_data;

    assign out_state = data;

    // Replace the bytes of the current chunk, leave the rest untouched
    always_comb begin
        int unsigned pos;
        pos      = 0;
        sub_data = data;
        for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
            pos = 8 * (32'(cnt) * BYTES_PER_CYCLE + i);
            sub_data[pos +: 8] = inv_sbox(data[pos +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            data      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (clear) begin
            fsm       <= IDLE;
            cnt       <= '0;
            data      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        data     <= in_state;
                        cnt      <= '0;
                        fsm      <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    data <= sub_data;
                    if (cnt == LAST_CHUNK) begin
                        cnt       <= '0;
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
